// File: rtl/uart_send.sv
// UART transmitter, 8N1 LSB first, with a registered serial line and valid/ready byte intake.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_send #(
   parameter int unsigned CLK_FREQ  = 27000000,
   parameter int unsigned UART_BPS  = 115200,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_en,
   input  logic [7:0] uart_din,
   output logic       uart_tx_ready,
   output logic       uart_tx_busy,
   output logic       uart_tx_done,
   output logic       uart_txd
);

   localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state, next_state;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic             stop_cnt, stop_cnt_nxt;
   logic [7:0]       tx_data, tx_data_nxt;
   logic             txd_nxt;
   logic             bit_end;
   logic             accept;

   assign bit_end = (clk_cnt == CNT_MAX);
   assign accept  = uart_en && (state == IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (accept) next_state = START;
         START:  if (bit_end) next_state = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:   if (bit_end && bit_cnt == 3'd7) next_state = PARITY;
         PARITY: if (bit_end) next_state = STOP;
`else
         DATA:   if (bit_end && bit_cnt == 3'd7) next_state = STOP;
`endif
         STOP:   if (bit_end && stop_cnt == STOP_LAST) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // bit_cnt wraps 7->0 on its own when DATA ends; stop_cnt wraps likewise for two stop bits
   always_comb begin
      clk_cnt_nxt  = '0;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      tx_data_nxt  = tx_data;
      if (state == IDLE) begin
         bit_cnt_nxt  = '0;
         stop_cnt_nxt = 1'b0;
         if (accept) tx_data_nxt = uart_din;
      end else begin
         clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
         if (bit_end && state == DATA) bit_cnt_nxt  = bit_cnt + 1'b1;
         if (bit_end && state == STOP) stop_cnt_nxt = stop_cnt + 1'b1;
      end
   end

   // Line level is decoded from the upcoming state so the registered txd lines up with it
   always_comb begin
      uart_tx_ready = (state == IDLE);
      uart_tx_busy  = (state != IDLE);
      uart_tx_done  = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
      case (next_state)
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = tx_data[bit_cnt_nxt];
`ifdef UART_TX_PARITY_EN
         PARITY:  txd_nxt = ^tx_data;
`endif
         default: txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx_data  <= '0;
         uart_txd <= 1'b1;
      end else begin
         clk_cnt  <= clk_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
         stop_cnt <= stop_cnt_nxt;
         tx_data  <= tx_data_nxt;
         uart_txd <= txd_nxt;
      end
   end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: cycle-exact line checks plus a line-decoding scoreboard.
// Honours UART_TX_PARITY_EN when the design is built with it.
`timescale 1ns/1ps
module tb_uart_send;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned UART_BPS = 100000;
   localparam int BIT = 10;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F1 = (1 + 8 + PAR + 1) * BIT;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       uart_en, uart_en2;
   logic [7:0] uart_din, uart_din2;
   logic       uart_tx_ready, uart_tx_busy, uart_tx_done, uart_txd;
   logic       ready2, busy2, done2, txd2;

   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         base;
   logic [7:0] exp_q[$];

   always #5 sys_clk = ~sys_clk;

   uart_send #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .STOP_BITS(1)) u_dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .uart_en      (uart_en),
      .uart_din     (uart_din),
      .uart_tx_ready(uart_tx_ready),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_done (uart_tx_done),
      .uart_txd     (uart_txd)
   );

   uart_send #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .STOP_BITS(2)) u_dut2 (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .uart_en      (uart_en2),
      .uart_din     (uart_din2),
      .uart_tx_ready(ready2),
      .uart_tx_busy (busy2),
      .uart_tx_done (done2),
      .uart_txd     (txd2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] st1();
      return {uart_txd, uart_tx_ready, uart_tx_busy, uart_tx_done};
   endfunction

   function automatic logic [3:0] st2();
      return {txd2, ready2, busy2, done2};
   endfunction

   // {txd, ready, busy, done} expected k cycles after the accept edge (k = 1 is the first start cycle)
   function automatic logic [3:0] exp_line(input logic [7:0] b, input int k, input int s);
      int   idx;
      int   f;
      logic txd;
      idx = (k - 1) / BIT;
      f   = (1 + 8 + PAR + s) * BIT;
      if (idx == 0)                   txd = 1'b0;
      else if (idx <= 8)              txd = b[idx-1];
      else if (PAR == 1 && idx == 9)  txd = ^b;
      else                            txd = 1'b1;
      return {txd, 1'b0, 1'b1, k == f};
   endfunction

   task automatic start_byte(input bit sel, input logic [7:0] b, input bit push);
      if (sel) begin
         uart_din2 = b;
         uart_en2  = 1'b1;
      end else begin
         uart_din = b;
         uart_en  = 1'b1;
         if (push) exp_q.push_back(b);
      end
   endtask

   task automatic check_frame(input bit sel, input logic [7:0] b, input int k0, input int k1,
                              input bit hold_en);
      int s = sel ? 2 : 1;
      for (int k = k0; k <= k1; k++) begin
         @(negedge sys_clk);
         if (k == 1 && !hold_en) begin
            if (sel) uart_en2 = 1'b0;
            else     uart_en  = 1'b0;
         end
         check($sformatf("%s_%02h k=%0d", sel ? "line2" : "line1", b, k),
               32'(sel ? st2() : st1()), 32'(exp_line(b, k, s)));
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge sys_clk);
         check(tag, 32'(st1()), 32'(4'b1100));
      end
   endtask

   // Line decoder for the STOP_BITS=1 instance; pops the scoreboard at the end of every frame
   int         mon_cnt = 0;
   bit         mon_active = 1'b0;
   logic [7:0] mon_byte = '0;
   logic       mon_par = 1'b0;
   logic       mon_stop = 1'b0;
   logic [7:0] mon_exp;

   always @(negedge sys_clk) begin
      if (uart_tx_done === 1'b1) done_cnt++;
      if (sys_rst_n !== 1'b1) begin
         mon_active = 1'b0;
      end else begin
         if (mon_active) mon_cnt++;
         else if (uart_txd === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
         end
         if (mon_active) begin
            if (mon_cnt >= 15 && mon_cnt < 95 && mon_cnt % 10 == 5)
               mon_byte[(mon_cnt - 15) / 10] = uart_txd;
            if (mon_cnt == 9 * BIT + 5) mon_par = uart_txd;
            if (mon_cnt == F1 - 5)      mon_stop = uart_txd;
            if (mon_cnt == F1 - 1) begin
               mon_active = 1'b0;
               check("sb_pending", 32'(exp_q.size() != 0), 32'(1));
               if (exp_q.size() != 0) begin
                  mon_exp = exp_q.pop_front();
                  check("sb_byte", 32'(mon_byte), 32'(mon_exp));
`ifdef UART_TX_PARITY_EN
                  check("sb_parity", 32'(mon_par), 32'(^mon_exp));
`endif
                  check("sb_stop", 32'(mon_stop), 32'(1'b1));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst_n = 1'b0;
      uart_en   = 1'b0;
      uart_en2  = 1'b0;
      uart_din  = '0;
      uart_din2 = '0;
      repeat (3) @(negedge sys_clk);
      check("rst_state", 32'(st1()), 32'(4'b1100));
      check("rst_state2", 32'(st2()), 32'(4'b1100));
      sys_rst_n = 1'b1;
      check_idle("idle_50", 50);

      // single frame, cycle-exact
      base = done_cnt;
      start_byte(0, 8'hA5, 1);
      check_frame(0, 8'hA5, 1, F1, 0);
      check_idle("a5_after", 1);
      check("a5_done_cnt", 32'(done_cnt - base), 32'(1));

      // uart_en held high: accepted in the first IDLE cycle, din change mid-frame ignored
      base = done_cnt;
      start_byte(0, 8'h55, 1);
      check_frame(0, 8'h55, 1, 1, 1);
      uart_din = 8'h0F;
      exp_q.push_back(8'h0F);
      check_frame(0, 8'h55, 2, F1, 1);
      check_idle("b2b_gap", 1);
      check_frame(0, 8'h0F, 1, F1, 0);
      check_idle("b2b_after", 1);
      check("b2b_done_cnt", 32'(done_cnt - base), 32'(2));

      // request while busy is dropped, not queued
      base = done_cnt;
      start_byte(0, 8'h00, 1);
      check_frame(0, 8'h00, 1, 35, 0);
      uart_din = 8'hFF;
      uart_en  = 1'b1;
      check_frame(0, 8'h00, 36, 36, 0);
      uart_en  = 1'b0;
      check_frame(0, 8'h00, 37, F1, 0);
      check_idle("no_second", 2 * F1);
      check("ign_done_cnt", 32'(done_cnt - base), 32'(1));

      // reset in data bit 3 (0xC3 has bit3 = 0, so the line must visibly rise)
      start_byte(0, 8'hC3, 0);
      check_frame(0, 8'hC3, 1, 45, 0);
      #2 sys_rst_n = 1'b0;
      #1;
      check("rst_mid_txd", 32'(uart_txd), 32'(1'b1));
      check("rst_mid_busy", 32'(uart_tx_busy), 32'(1'b0));
      check("rst_mid_ready", 32'(uart_tx_ready), 32'(1'b1));
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      check_idle("rst_release", 5);
      start_byte(0, 8'h3C, 1);
      check_frame(0, 8'h3C, 1, F1, 0);
      check_idle("3c_after", 1);

`ifdef UART_TX_PARITY_EN
      start_byte(0, 8'h07, 1);
      check_frame(0, 8'h07, 1, 95, 0);
      check("parity_07", 32'(uart_txd), 32'(1'b1));
      check_frame(0, 8'h07, 96, F1, 0);
      check_idle("p07_after", 1);
      start_byte(0, 8'h03, 1);
      check_frame(0, 8'h03, 1, 95, 0);
      check("parity_03", 32'(uart_txd), 32'(1'b0));
      check_frame(0, 8'h03, 96, F1, 0);
      check_idle("p03_after", 1);
`endif

      // two stop bits on the second instance
      start_byte(1, 8'h96, 0);
      check_frame(1, 8'h96, 1, (1 + 8 + PAR + 2) * BIT, 0);
      @(negedge sys_clk);
      check("stop2_after", 32'(st2()), 32'(4'b1100));

      check_idle("final_idle", 3);
      check("sb_drain", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
